ex_stage: RTL and testbench

- Execute stage of the 64-bit in-order pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs every cycle.
- It performs ALU operations, resolves branches and jumps, and produces a registered EX/MEM bundle plus a registered PC redirect.
- After a taken redirect it squashes a fixed number of younger instructions, using an internal counter.

---
 rtl/ex_stage_if.sv | 45 ++++
 rtl/ex_stage.sv | 131 +++++++++++++
 tb/tb_ex_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX -> EX bundle and the registered EX/MEM + redirect bundle of the execute stage.
interface ex_stage_if;
  // ID/EX side
  logic        WRegEn_in;
  logic        WMemEn_in;
  logic        mem_to_reg_in;
  logic        rs2_swch_in;
  logic [63:0] R1out_in;
  logic [63:0] R2out_in;
  logic [63:0] sign_ext_in;
  logic [4:0]  WReg1_in;
  logic [2:0]  func3_in;
  logic        func7_in;
  logic        jal_in;
  logic        jalr_in;
  logic        br_in;
  logic [7:0]  pc_in;
  // EX/MEM side
  logic [63:0] alu_result_out;
  logic [63:0] store_data_out;
  logic [4:0]  WReg1_out;
  logic        WRegEn_out;
  logic        WMemEn_out;
  logic        mem_to_reg_out;
  logic [2:0]  func3_out;
  logic        redirect_out;
  logic [7:0]  redirect_pc_out;
  logic [1:0]  squash_cnt_out;

  // The execute stage itself
  modport slave (
    input  WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in, R1out_in, R2out_in,
           sign_ext_in, WReg1_in, func3_in, func7_in, jal_in, jalr_in, br_in, pc_in,
    output alu_result_out, store_data_out, WReg1_out, WRegEn_out, WMemEn_out,
           mem_to_reg_out, func3_out, redirect_out, redirect_pc_out, squash_cnt_out
  );

  // Upstream pipeline register / downstream consumer
  modport master (
    output WRegEn_in, WMemEn_in, mem_to_reg_in, rs2_swch_in, R1out_in, R2out_in,
           sign_ext_in, WReg1_in, func3_in, func7_in, jal_in, jalr_in, br_in, pc_in,
    input  alu_result_out, store_data_out, WReg1_out, WRegEn_out, WMemEn_out,
           mem_to_reg_out, func3_out, redirect_out, redirect_pc_out, squash_cnt_out
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, registered EX/MEM bundle and PC redirect.
// A taken, unsquashed branch/jump kills the side effects of the next SQUASH_DEPTH
// instructions via a small down-counter.
module ex_stage #(
  parameter int unsigned SQUASH_DEPTH = 2   // 0..3
) (
  input  logic       CLK,
  input  logic       RST,
  ex_stage_if.slave  bus
);

  logic [63:0] op_b;
  logic [5:0]  shamt;
  logic [63:0] alu_op;
  logic [63:0] alu_d;
  logic        br_cond;
  logic        taken;
  logic [7:0]  target;
  logic        squash;
  logic        redirect_d;
  logic [7:0]  redirect_pc_d;
  logic [1:0]  cnt_d;

  logic [63:0] alu_q;
  logic [63:0] store_q;
  logic [4:0]  wreg1_q;
  logic        wregen_q;
  logic        wmemen_q;
  logic        m2r_q;
  logic [2:0]  func3_q;
  logic        redirect_q;
  logic [7:0]  redirect_pc_q;
  logic [1:0]  cnt_q;

  // ALU, branch condition, target and squash counter next-state
  always_comb begin
    op_b  = bus.rs2_swch_in ? bus.sign_ext_in : bus.R2out_in;
    shamt = op_b[5:0];

    alu_op = '0;
    unique case (bus.func3_in)
      3'b000: alu_op = (bus.func7_in && !bus.rs2_swch_in) ? bus.R1out_in - op_b
                                                          : bus.R1out_in + op_b;
      3'b001: alu_op = bus.R1out_in << shamt;
      3'b010: alu_op = {63'd0, $signed(bus.R1out_in) < $signed(op_b)};
      3'b011: alu_op = {63'd0, bus.R1out_in < op_b};
      3'b100: alu_op = bus.R1out_in ^ op_b;
      3'b101: alu_op = bus.func7_in ? 64'($signed(bus.R1out_in) >>> shamt)
                                    : bus.R1out_in >> shamt;
      3'b110: alu_op = bus.R1out_in | op_b;
      3'b111: alu_op = bus.R1out_in & op_b;
      default: alu_op = '0;
    endcase

    // Jump link value beats address generation, which beats branch subtraction.
    alu_d = alu_op;
    if (bus.jal_in || bus.jalr_in)
      alu_d = {56'd0, bus.pc_in} + 64'd1;
    else if (bus.mem_to_reg_in || bus.WMemEn_in)
      alu_d = bus.R1out_in + bus.sign_ext_in;
    else if (bus.br_in)
      alu_d = bus.R1out_in - op_b;

    br_cond = 1'b0;
    unique case (bus.func3_in)
      3'b000: br_cond = (bus.R1out_in == bus.R2out_in);
      3'b001: br_cond = (bus.R1out_in != bus.R2out_in);
      3'b100: br_cond = ($signed(bus.R1out_in) <  $signed(bus.R2out_in));
      3'b101: br_cond = ($signed(bus.R1out_in) >= $signed(bus.R2out_in));
      3'b110: br_cond = (bus.R1out_in <  bus.R2out_in);
      3'b111: br_cond = (bus.R1out_in >= bus.R2out_in);
      default: br_cond = 1'b0;
    endcase

    taken = bus.jalr_in || bus.jal_in || (bus.br_in && br_cond);

    // Only the low byte of R1 + imm matters for the 8-bit jalr target.
    target = bus.jalr_in ? (bus.R1out_in[7:0] + bus.sign_ext_in[7:0])
                         : (bus.pc_in + bus.sign_ext_in[7:0]);

    squash        = (cnt_q != 2'd0);
    redirect_d    = taken && !squash;
    redirect_pc_d = redirect_d ? target : redirect_pc_q;

    if (squash)
      cnt_d = cnt_q - 2'd1;
    else if (taken)
      cnt_d = 2'(SQUASH_DEPTH);
    else
      cnt_d = cnt_q;
  end

  // EX/MEM register; squashed instructions keep data but lose all side effects
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_q         <= '0;
      store_q       <= '0;
      wreg1_q       <= '0;
      wregen_q      <= 1'b0;
      wmemen_q      <= 1'b0;
      m2r_q         <= 1'b0;
      func3_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      alu_q         <= alu_d;
      store_q       <= bus.R2out_in;
      wreg1_q       <= bus.WReg1_in;
      wregen_q      <= bus.WRegEn_in && !squash;
      wmemen_q      <= bus.WMemEn_in && !squash;
      m2r_q         <= bus.mem_to_reg_in && !squash;
      func3_q       <= bus.func3_in;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.alu_result_out  = alu_q;
  assign bus.store_data_out  = store_q;
  assign bus.WReg1_out       = wreg1_q;
  assign bus.WRegEn_out      = wregen_q;
  assign bus.WMemEn_out      = wmemen_q;
  assign bus.mem_to_reg_out  = m2r_q;
  assign bus.func3_out       = func3_q;
  assign bus.redirect_out    = redirect_q;
  assign bus.redirect_pc_out = redirect_pc_q;
  assign bus.squash_cnt_out  = cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed cases followed by random instructions,
// every output compared against a behavioural model of the execute stage.
module tb_ex_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic        wreg, wmem, m2r, rs2sw;
    logic [63:0] r1, r2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7, jal, jalr, br;
    logic [7:0]  pc;
  } instr_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  ex_stage_if bus();

  ex_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int         m_cnt = 0;
  logic [7:0] m_rpc = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t t;
    t.wreg = 0; t.wmem = 0; t.m2r = 0; t.rs2sw = 0;
    t.r1 = '0; t.r2 = '0; t.imm = '0; t.rd = '0; t.f3 = '0;
    t.f7 = 0; t.jal = 0; t.jalr = 0; t.br = 0; t.pc = '0;
    return t;
  endfunction

  // Reference: shifts written as multiply/divide by powers of two.
  function automatic logic [63:0] ref_result(input instr_t t);
    logic [63:0] b, p2;
    b  = t.rs2sw ? t.imm : t.r2;
    p2 = 64'd1 << b[5:0];
    if (t.jal || t.jalr) return 64'(t.pc) + 64'd1;
    if (t.m2r || t.wmem) return t.r1 + t.imm;
    if (t.br)            return t.r1 - b;
    case (t.f3)
      3'd0: return (t.f7 && !t.rs2sw) ? t.r1 - b : t.r1 + b;
      3'd1: return t.r1 * p2;
      3'd2: return ($signed(t.r1) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: return (t.r1 < b) ? 64'd1 : 64'd0;
      3'd4: return t.r1 ^ b;
      3'd5: return (t.f7 && t.r1[63]) ? ~((~t.r1) / p2) : t.r1 / p2;
      3'd6: return t.r1 | b;
      default: return t.r1 & b;
    endcase
  endfunction

  function automatic logic ref_taken(input instr_t t);
    logic c;
    case (t.f3)
      3'd0: c = (t.r1 == t.r2);
      3'd1: c = (t.r1 != t.r2);
      3'd4: c = ($signed(t.r1) <  $signed(t.r2));
      3'd5: c = ($signed(t.r1) >= $signed(t.r2));
      3'd6: c = (t.r1 <  t.r2);
      3'd7: c = (t.r1 >= t.r2);
      default: c = 1'b0;
    endcase
    return t.jal || t.jalr || (t.br && c);
  endfunction

  function automatic logic [7:0] ref_target(input instr_t t);
    logic [63:0] s;
    if (t.jalr) begin
      s = t.r1 + t.imm;
      return s[7:0];
    end
    return 8'((int'(t.pc) + int'(t.imm[7:0])) % 256);
  endfunction

  task automatic drive(input instr_t t);
    bus.WRegEn_in     = t.wreg;
    bus.WMemEn_in     = t.wmem;
    bus.mem_to_reg_in = t.m2r;
    bus.rs2_swch_in   = t.rs2sw;
    bus.R1out_in      = t.r1;
    bus.R2out_in      = t.r2;
    bus.sign_ext_in   = t.imm;
    bus.WReg1_in      = t.rd;
    bus.func3_in      = t.f3;
    bus.func7_in      = t.f7;
    bus.jal_in        = t.jal;
    bus.jalr_in       = t.jalr;
    bus.br_in         = t.br;
    bus.pc_in         = t.pc;
  endtask

  task automatic step(input instr_t t);
    logic [63:0] e_alu;
    logic        sq, tk;
    logic [7:0]  tgt;
    @(negedge CLK);
    RST = 1'b0;
    drive(t);
    e_alu = ref_result(t);
    sq    = (m_cnt != 0);
    tk    = ref_taken(t);
    tgt   = ref_target(t);
    @(posedge CLK);
    #1;
    if (tk && !sq) m_rpc = tgt;
    m_cnt = sq ? m_cnt - 1 : (tk ? DEPTH : 0);
    chk("alu_result", bus.alu_result_out, e_alu);
    chk("store_data", bus.store_data_out, t.r2);
    chk("wreg1",      64'(bus.WReg1_out), 64'(t.rd));
    chk("wregen",     64'(bus.WRegEn_out), 64'(t.wreg && !sq));
    chk("wmemen",     64'(bus.WMemEn_out), 64'(t.wmem && !sq));
    chk("mem_to_reg", 64'(bus.mem_to_reg_out), 64'(t.m2r && !sq));
    chk("func3",      64'(bus.func3_out), 64'(t.f3));
    chk("redirect",   64'(bus.redirect_out), 64'(tk && !sq));
    chk("redirect_pc", 64'(bus.redirect_pc_out), 64'(m_rpc));
    chk("squash_cnt", 64'(bus.squash_cnt_out), 64'(m_cnt));
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    t = nop();
    t.r1    = {$urandom, $urandom};
    t.r2    = ($urandom_range(0, 3) == 0) ? t.r1 : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) t.r2 = 64'($urandom_range(0, 9)) - 64'd5;
    t.imm   = ($urandom_range(0, 1) == 0) ? 64'($signed(12'($urandom))) : {$urandom, $urandom};
    t.rd    = 5'($urandom);
    t.f3    = 3'($urandom);
    t.f7    = 1'($urandom);
    t.rs2sw = 1'($urandom);
    t.wreg  = 1'($urandom);
    t.pc    = 8'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      4: begin t.m2r = 1; t.wreg = 1; end
      5: begin t.wmem = 1; t.wreg = 0; end
      6, 7: t.br = 1;
      8: t.jal = 1;
      9: t.jalr = 1;
      default: ;
    endcase
    if ($urandom_range(0, 19) == 0) begin
      t.jal = 1'($urandom); t.jalr = 1'($urandom); t.br = 1'($urandom);
    end
    return t;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    drive(rand_instr());
    @(posedge CLK);
    #1;
    m_cnt = 0;
    m_rpc = 8'h00;
    chk("rst_alu",        bus.alu_result_out, 64'd0);
    chk("rst_store",      bus.store_data_out, 64'd0);
    chk("rst_wreg1",      64'(bus.WReg1_out), 64'd0);
    chk("rst_wregen",     64'(bus.WRegEn_out), 64'd0);
    chk("rst_wmemen",     64'(bus.WMemEn_out), 64'd0);
    chk("rst_m2r",        64'(bus.mem_to_reg_out), 64'd0);
    chk("rst_func3",      64'(bus.func3_out), 64'd0);
    chk("rst_redirect",   64'(bus.redirect_out), 64'd0);
    chk("rst_redirect_pc", 64'(bus.redirect_pc_out), 64'd0);
    chk("rst_squash_cnt", 64'(bus.squash_cnt_out), 64'd0);
  endtask

  initial begin
    instr_t t;
    drive(nop());
    do_reset();

    // R-type SUB
    t = nop(); t.r1 = 64'd5; t.r2 = 64'd7; t.f7 = 1; t.wreg = 1; t.rd = 5'd3;
    step(t);
    chk("sub_const", bus.alu_result_out, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_wregen", 64'(bus.WRegEn_out), 64'd1);

    // Immediate SRA / SRL
    t = nop(); t.r1 = 64'h8000_0000_0000_0000; t.imm = 64'd4; t.f3 = 3'b101;
    t.f7 = 1; t.rs2sw = 1; t.wreg = 1;
    step(t);
    chk("srai_const", bus.alu_result_out, 64'hF800_0000_0000_0000);
    t.f7 = 0;
    step(t);
    chk("srli_const", bus.alu_result_out, 64'h0800_0000_0000_0000);

    // Taken BLT with PC wrap, then two squashed stores and one live store
    t = nop(); t.br = 1; t.f3 = 3'b100; t.r1 = '1; t.r2 = 64'd1; t.pc = 8'hFE; t.imm = 64'd4;
    step(t);
    chk("blt_redirect", 64'(bus.redirect_out), 64'd1);
    chk("blt_target", 64'(bus.redirect_pc_out), 64'h02);
    t = nop(); t.wmem = 1; t.r1 = 64'h100; t.imm = 64'd8; t.r2 = 64'hDEAD; t.f3 = 3'b011;
    step(t);
    chk("sq_store1", 64'(bus.WMemEn_out), 64'd0);
    chk("sq_store1_redir", 64'(bus.redirect_out), 64'd0);
    step(t);
    chk("sq_store2", 64'(bus.WMemEn_out), 64'd0);
    step(t);
    chk("live_store", 64'(bus.WMemEn_out), 64'd1);
    chk("live_store_addr", bus.alu_result_out, 64'h108);

    // JALR
    t = nop(); t.jalr = 1; t.r1 = 64'h10; t.imm = 64'hFFFF_FFFF_FFFF_FFFE; t.pc = 8'h40;
    t.rd = 5'd1; t.wreg = 1;
    step(t);
    chk("jalr_target", 64'(bus.redirect_pc_out), 64'h0E);
    chk("jalr_link", bus.alu_result_out, 64'h41);
    step(nop());
    step(nop());

    // Taken BEQ inside the JAL squash window
    t = nop(); t.jal = 1; t.pc = 8'h10; t.imm = 64'd8; t.wreg = 1;
    step(t);
    chk("jal_target", 64'(bus.redirect_pc_out), 64'h18);
    t = nop(); t.br = 1; t.f3 = 3'b000; t.r1 = 64'd7; t.r2 = 64'd7; t.pc = 8'h20; t.imm = 64'h10;
    step(t);
    chk("beq_sq_redirect", 64'(bus.redirect_out), 64'd0);
    chk("beq_sq_cnt", 64'(bus.squash_cnt_out), 64'd1);
    chk("beq_sq_pc", 64'(bus.redirect_pc_out), 64'h18);
    step(nop());

    // Reset in the middle of a squash window
    t = nop(); t.jal = 1; t.pc = 8'h30; t.imm = 64'h4;
    step(t);
    chk("pre_rst_cnt", 64'(bus.squash_cnt_out), 64'd2);
    do_reset();
    t = nop(); t.wmem = 1; t.r1 = 64'h20; t.imm = 64'h4;
    step(t);
    chk("post_rst_store", 64'(bus.WMemEn_out), 64'd1);

    // Random instruction stream
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step(rand_instr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
